lfsr_count_decoder: RTL and testbench
=====================================

# lfsr_count_decoder

Converts an 8-bit LFSR counter value back into its binary step index, counting from the reset state 0x00. It is the decoder for the team's XNOR-feedback up/down LFSR counter. It sits on the observation side of that counter, so debug and test logic can read its position as a plain integer. Decoding is sequential: a local LFSR replays the sequence from 0x00 until it matches the sample, with ready/valid handshakes on both sides.

## Interface
- `WIDTH`, 8: LFSR and index width.
- `TAPS_UP`, 8'b01100011: feedback mask for the up direction (right shift, new MSB).
- `TAPS_DN`, 8'b10110001: feedback mask for the down direction (left shift, new LSB).
- `clk`  in  1: single clock; all logic on posedge.
- `reset`  in  1: synchronous, active-high.
- `in_valid`  in  1: sample request.
- `in_ready`  out  1: decoder idle; request accepted when `in_valid & in_ready`.
- `in_count`  in  WIDTH: LFSR value to decode.
- `in_up_down`  in  1: 1 = up sequence, 0 = down sequence.
- `out_valid`  out  1: result available.
- `out_ready`  in  1: consumer accepts the result when `out_valid & out_ready`.
- `out_index`  out  WIDTH: number of steps from 0x00 to `in_count`.
- `out_error`  out  1: no match within 2^WIDTH-1 steps.

## Operation
- Step rules, applied to local state `s`:
  - Up: `s <= {~^(s & TAPS_UP), s[WIDTH-1:1]}`.
  - Down: `s <= {s[WIDTH-2:0], ~^(s & TAPS_DN)}`.
- FSM has three states: IDLE, SEARCH, DONE.
- IDLE:
  - `in_ready`=1.
  - On accept, register `in_count` as the target and `in_up_down` as the direction.
  - Set `s`=0, `idx`=0, then go to SEARCH.
- SEARCH (`in_ready`=0), evaluated in this order each cycle:
  - If `s`==target: `out_index`<=`idx`, `out_error`<=0, go to DONE.
  - Else if `idx`==2^WIDTH-2: `out_index`<=all-ones, `out_error`<=1, go to DONE.
  - Else: step `s` and increment `idx`.
- DONE:
  - `out_valid`=1; `out_index` and `out_error` hold stable until `out_ready`.
  - On `out_valid & out_ready`, go to IDLE.
  - No new request is accepted in the same cycle as the result handshake.
- Sample 0x00 matches on the first SEARCH cycle and gives index 0.
- Value 0xFF is the XNOR lock-up state; it never matches and always returns error.
- `idx` never wraps; the error check ends the search first.
- Direction and target are sampled only at accept; changes on `in_*` during SEARCH or DONE are ignored.

## Timing
- Reset values: `in_ready`=0 during reset and 1 the cycle after; `out_valid`=0, `out_index`=0, `out_error`=0; FSM in IDLE.
- Reset mid-SEARCH or in DONE aborts the decode. Any pending result is discarded without a handshake.
- Latency for a matching index k: `out_valid` rises k+2 clocks after the accept edge.
- Latency for error: `out_valid` rises 2^WIDTH clocks after the accept edge (256 for WIDTH=8).
- Throughput: one decode in flight; `in_ready` is low from the accept edge until the result handshake.
- `out_ready` held high: DONE lasts exactly one cycle, and IDLE is re-entered the next cycle.

## Configuration
- `LFSR_DEC_DOWN_EN` defined:
  - `in_up_down` selects the step rule.
  - The `TAPS_DN` path is compiled in.
- `LFSR_DEC_DOWN_EN` undefined:
  - Only the up rule is built.
  - `in_up_down` is still present in the port list but is ignored.
  - Down requests decode as up.

## Structure
- Shared package `lfsr_pkg` holds:
  - `WIDTH` default;
  - `TAPS_UP` and `TAPS_DN`;
  - FSM state encoding constants (IDLE=2'd0, SEARCH=2'd1, DONE=2'd2);
  - the lock-up constant (all-ones).
- Sub-module `lfsr_step`: combinational next-state for one LFSR step.
  - Inputs: `s`, `dir`. Output: `s_next`.
  - Shared with the counter, so encoder and decoder cannot diverge.

## Test plan
- Reset asserted mid-stream → all outputs at reset values the next cycle; `in_ready`=1 one cycle after reset deasserts.
- Up, `in_count`=0x00 → `out_index`=0, `out_error`=0; `out_valid` 2 clocks after accept.
- Up, `in_count`=0x80 → `out_index`=1. Up, `in_count`=0xC0 → `out_index`=2, latency 4 clocks.
- Down (macro on), `in_count`=0x01 → index 1; `in_count`=0x02 → index 2. Macro off, same down request on 0x02 → decoded as up (no early match).
- `in_count`=0xFF → `out_error`=1, `out_index`=0xFF, `out_valid` 256 clocks after accept.
- Back-pressure and abort:
  - Hold `out_ready`=0 for 10 cycles → `out_valid` and data stable, `in_ready`=0.
  - Toggle `in_*` meanwhile → no effect.
  - Reset during SEARCH → result never appears.
- Exhaustive cross-check against the LFSR counter model: for every reachable state, `out_index` equals the number of enable pulses applied since reset.

Source files
------------

// File: rtl/lfsr_count_decoder_pkg.sv
// rtl/lfsr_count_decoder_pkg.sv - shared constants and types for the XNOR LFSR counter family
//
// Package lfsr_pkg: default LFSR width, feedback masks for both step
// directions, the decoder FSM state encoding and the XNOR lock-up value.
// Imported by the decoder, its interface and the step sub-module so the
// counter and decoder agree on one definition of the sequence.
package lfsr_pkg;

  localparam int LFSR_WIDTH = 8;

  // Up: right shift, feedback enters at the MSB.
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS_UP = 8'b01100011;
  // Down: left shift, feedback enters at the LSB.
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS_DN = 8'b10110001;

  // With XNOR feedback the all-ones word maps onto itself in both
  // directions, so it is never part of the sequence started from zero.
  localparam logic [LFSR_WIDTH-1:0] LFSR_LOCKUP = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } dec_state_t;

endpackage

// File: rtl/lfsr_count_decoder_if.sv
// rtl/lfsr_count_decoder_if.sv - request/result handshake bundle for the LFSR decoder
//
// Signals:
//   in_valid   requester -> decoder  sample request
//   in_ready   decoder -> requester  decoder idle, request accepted on valid & ready
//   in_count   requester -> decoder  LFSR value to decode
//   in_up_down requester -> decoder  1 = up sequence, 0 = down sequence
//   out_valid  decoder -> consumer   result available
//   out_ready  consumer -> decoder   result taken on valid & ready
//   out_index  decoder -> consumer   steps from 0x00 to in_count
//   out_error  decoder -> consumer   no match within 2^WIDTH-1 steps
// Modports: master (requester/consumer side), slave (decoder side).
interface lfsr_count_decoder_if
  import lfsr_pkg::*;
#(
  parameter int WIDTH = LFSR_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_count;
  logic             in_up_down;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_index;
  logic             out_error;

  modport master (
    output in_valid,
    output in_count,
    output in_up_down,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_index,
    input  out_error
  );

  modport slave (
    input  in_valid,
    input  in_count,
    input  in_up_down,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_index,
    output out_error
  );

endinterface

// File: rtl/lfsr_count_decoder_step.sv
// rtl/lfsr_count_decoder_step.sv - combinational single step of the XNOR up/down LFSR
//
// Module lfsr_step, shared with the counter so encoder and decoder cannot
// drift apart.
// Ports:
//   s      in   WIDTH  current LFSR state
//   dir    in   1      1 = up step, 0 = down step
//   s_next out  WIDTH  state after one step
// Build option LFSR_DEC_DOWN_EN: when defined, dir selects the rule and the
// down path is built; when undefined, only the up rule exists and dir is ignored.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int               WIDTH   = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS_UP = WIDTH'(LFSR_TAPS_UP),
  parameter logic [WIDTH-1:0] TAPS_DN = WIDTH'(LFSR_TAPS_DN)
) (
  input  logic [WIDTH-1:0] s,
  input  logic             dir,
  output logic [WIDTH-1:0] s_next
);

`ifdef LFSR_DEC_DOWN_EN
  always_comb begin
    if (dir) begin
      s_next = {~^(s & TAPS_UP), s[WIDTH-1:1]};
    end else begin
      s_next = {s[WIDTH-2:0], ~^(s & TAPS_DN)};
    end
  end
`else
  // Down rule not built: direction and down mask are accepted but unused.
  logic             unused_dir;
  logic [WIDTH-1:0] unused_taps_dn;
  assign unused_dir     = dir;
  assign unused_taps_dn = TAPS_DN;

  always_comb begin
    s_next = {~^(s & TAPS_UP), s[WIDTH-1:1]};
  end
`endif

endmodule

// File: rtl/lfsr_count_decoder.sv
// rtl/lfsr_count_decoder.sv - sequential decoder from LFSR counter value to binary step index
//
// Replays the counter sequence from 0x00 with a local LFSR until it equals
// the sampled value; the number of steps taken is the index.
// Ports:
//   clk    in  single clock, posedge
//   reset  in  synchronous, active-high
//   bus    lfsr_count_decoder_if.slave: in_valid/in_ready/in_count/in_up_down
//          request side, out_valid/out_ready/out_index/out_error result side
// Build option LFSR_DEC_DOWN_EN: enables the down-direction decode; without it
// every request is decoded against the up sequence.
module lfsr_count_decoder
  import lfsr_pkg::*;
#(
  parameter int               WIDTH   = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS_UP = WIDTH'(LFSR_TAPS_UP),
  parameter logic [WIDTH-1:0] TAPS_DN = WIDTH'(LFSR_TAPS_DN)
) (
  input  logic                 clk,
  input  logic                 reset,
  lfsr_count_decoder_if.slave  bus
);

  // Last index that can still be tested: 2^WIDTH-2. The sequence holds at
  // most 2^WIDTH-1 distinct states, so idx never needs to wrap.
  localparam logic [WIDTH-1:0] IDX_LAST = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  dec_state_t       state_q;
  dec_state_t       state_d;
  logic [WIDTH-1:0] target_q;
  logic             dir_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] s_next;
  logic [WIDTH-1:0] idx_q;
  logic [WIDTH-1:0] index_q;
  logic             error_q;
  logic             accept;
  logic             match;
  logic             exhausted;

  lfsr_step #(
    .WIDTH   (WIDTH),
    .TAPS_UP (TAPS_UP),
    .TAPS_DN (TAPS_DN)
  ) u_step (
    .s      (s_q),
    .dir    (dir_q),
    .s_next (s_next)
  );

  assign match     = (s_q == target_q);
  assign exhausted = (idx_q == IDX_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Match is tested before exhaustion so that a hit on
  // the last testable index still reports a valid result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (match || exhausted) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs. in_ready is gated by reset so it reads low for the whole reset
  // cycle, and being tied to IDLE it is low on the result-handshake cycle.
  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE) && !reset;
    bus.out_valid = (state_q == ST_DONE);
    bus.out_index = index_q;
    bus.out_error = error_q;
    accept        = bus.in_valid && (state_q == ST_IDLE) && !reset;
  end

  // Search datapath. Target and direction are captured only at accept, so
  // anything on the request inputs during SEARCH/DONE has no effect.
  always_ff @(posedge clk) begin
    if (reset) begin
      target_q <= '0;
      dir_q    <= 1'b0;
      s_q      <= '0;
      idx_q    <= '0;
      index_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            target_q <= bus.in_count;
            dir_q    <= bus.in_up_down;
            s_q      <= '0;
            idx_q    <= '0;
          end
        end
        ST_SEARCH: begin
          if (match) begin
            index_q <= idx_q;
            error_q <= 1'b0;
          end else if (exhausted) begin
            index_q <= ALL_ONES;
            error_q <= 1'b1;
          end else begin
            s_q   <= s_next;
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_count_decoder.sv
// tb/tb_lfsr_count_decoder.sv - self-checking bench for lfsr_count_decoder
module tb_lfsr_count_decoder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lfsr_count_decoder_if #(.WIDTH(8)) bus();

  lfsr_count_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int up_pos[256];
  int dn_pos[256];
  int order[256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counter model: walk the sequence from 0x00 applying one enable pulse at a
  // time and remember how many pulses first reached each value.
  task automatic build_tables();
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      up_pos[i] = -1;
      dn_pos[i] = -1;
    end
    v = 8'h00;
    for (int k = 0; k < 255; k++) begin
      if (up_pos[v] < 0) up_pos[v] = k;
      v = {~^(v & 8'b01100011), v[7:1]};
    end
    v = 8'h00;
    for (int k = 0; k < 255; k++) begin
      if (dn_pos[v] < 0) dn_pos[v] = k;
      v = {v[6:0], ~^(v & 8'b10110001)};
    end
  endtask

  task automatic decode(input string tag, input logic [7:0] cnt, input logic dir, input int hold);
    int pos;
    int lat;
    int n;
    int exp_lat;
    logic [7:0] exp_idx;
    logic exp_err;
`ifdef LFSR_DEC_DOWN_EN
    pos = dir ? up_pos[cnt] : dn_pos[cnt];
`else
    pos = up_pos[cnt];
`endif
    if (pos >= 0) begin
      exp_idx = pos[7:0];
      exp_err = 1'b0;
      exp_lat = pos + 2;
    end else begin
      exp_idx = 8'hFF;
      exp_err = 1'b1;
      exp_lat = 256;
    end
    n = 0;
    while (!bus.in_ready && n < 20) begin
      step();
      n++;
    end
    check({tag, " in_ready idle"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid   = 1'b1;
    bus.in_count   = cnt;
    bus.in_up_down = dir;
    bus.out_ready  = 1'b0;
    step();
    lat = 1;
    bus.in_valid = 1'b0;
    check({tag, " in_ready busy"}, 32'(bus.in_ready), 32'd0);
    while (!bus.out_valid && lat < 300) begin
      bus.in_valid   = 1'($urandom);
      bus.in_count   = 8'($urandom);
      bus.in_up_down = 1'($urandom);
      step();
      lat++;
    end
    bus.in_valid = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " index"}, 32'(bus.out_index), 32'(exp_idx));
    check({tag, " error"}, 32'(bus.out_error), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      bus.in_count   = 8'($urandom);
      bus.in_up_down = 1'($urandom);
      step();
      check({tag, " hold valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, " hold index"}, 32'(bus.out_index), 32'(exp_idx));
      check({tag, " hold error"}, 32'(bus.out_error), 32'(exp_err));
      check({tag, " hold in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, " valid drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, " idle again"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int n;
    int seen;
    int j;
    int tmp;
    bus.in_valid   = 1'b0;
    bus.in_count   = 8'h00;
    bus.in_up_down = 1'b1;
    bus.out_ready  = 1'b0;
    build_tables();

    reset = 1'b1;
    step();
    step();
    check("rst in_ready", 32'(bus.in_ready), 32'd0);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst out_index", 32'(bus.out_index), 32'd0);
    check("rst out_error", 32'(bus.out_error), 32'd0);
    reset = 1'b0;
    step();
    check("post-rst in_ready", 32'(bus.in_ready), 32'd1);

    decode("up 00", 8'h00, 1'b1, 0);
    decode("up 80", 8'h80, 1'b1, 0);
    decode("up C0", 8'hC0, 1'b1, 0);
    decode("dn 01", 8'h01, 1'b0, 0);
    decode("dn 02", 8'h02, 1'b0, 0);
    decode("lockup FF", 8'hFF, 1'b1, 0);
    decode("backpressure", 8'h5A, 1'b1, 10);

    // Reset during SEARCH: the pending result must never show up.
    bus.in_valid = 1'b1;
    bus.in_count = 8'hFF;
    bus.in_up_down = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (20) step();
    reset = 1'b1;
    step();
    check("abort rst in_ready", 32'(bus.in_ready), 32'd0);
    check("abort rst out_valid", 32'(bus.out_valid), 32'd0);
    reset = 1'b0;
    step();
    check("abort in_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (bus.out_valid) seen++;
    end
    check("abort no result", 32'(seen), 32'd0);

    // Reset while a result waits in DONE.
    bus.in_valid = 1'b1;
    bus.in_count = 8'hC0;
    step();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
    end
    check("done reached", 32'(bus.out_valid), 32'd1);
    reset = 1'b1;
    step();
    check("done rst out_valid", 32'(bus.out_valid), 32'd0);
    check("done rst out_index", 32'(bus.out_index), 32'd0);
    check("done rst out_error", 32'(bus.out_error), 32'd0);
    reset = 1'b0;
    step();

    // Every byte value in shuffled order against the counter model.
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      decode($sformatf("exh up %02h", order[i]), 8'(order[i]), 1'b1, int'($urandom_range(2, 0)));
    end

`ifdef LFSR_DEC_DOWN_EN
    for (int i = 0; i < 12; i++) begin
      tmp = int'($urandom_range(255, 0));
      decode($sformatf("rnd dn %02h", tmp), 8'(tmp), 1'b0, int'($urandom_range(2, 0)));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
